// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Active-low pin idle values and FSM encoding live here.
package seg_scan_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef struct packed {
    logic [3:0]  dp;
    logic [15:0] data;
  } disp_word_t;

endpackage

// File: rtl/seg_scan_if.sv
// Valid/ready load port carrying one display word.
// The master offers a word, the controller accepts it.
interface seg_scan_if;

  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a}.
// Letters b and d use lowercase glyphs.
module hex_to_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed display scanner with blanking window
// and a double-buffered load port; all pins registered.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV_MAX   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lz_suppress,
  seg_scan_if.slave   ld,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  logic [1:0]       st;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  disp_word_t       act;
  disp_word_t       pnd;
  logic             pend;

  logic       scan, slot_end, wrap;
  logic       accept, commit, drive;
  logic       z3, z2, z1, lz_blank;
  logic [3:0] nib;
  logic [6:0] seg_raw;

  assign scan     = (st != ST_IDLE);
  assign slot_end = (div == DIV_W'(DIV_MAX - 1));
  assign wrap     = scan & en & slot_end & (idx == 2'd3);
  assign drive    = (st == ST_DRIVE);

  // pend is the pre-edge value, so a word taken at the wrap waits a frame
  assign accept = ld.load_valid & ~pend;
  assign commit = pend & (wrap | (st == ST_IDLE));
  assign ld.load_ready = ~pend;

  assign z3 = (act.data[15:12] == 4'h0);
  assign z2 = z3 & (act.data[11:8] == 4'h0);
  assign z1 = z2 & (act.data[7:4] == 4'h0);

  always_comb begin
    nib      = act.data[3:0];
    lz_blank = 1'b0;
    case (idx)
      2'd0: nib = act.data[3:0];
      2'd1: begin
        nib      = act.data[7:4];
        lz_blank = z1;
      end
      2'd2: begin
        nib      = act.data[11:8];
        lz_blank = z2;
      end
      2'd3: begin
        nib      = act.data[15:12];
        lz_blank = z3;
      end
      default: nib = act.data[3:0];
    endcase
  end

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (seg_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= ST_IDLE;
      div <= '0;
      idx <= '0;
    end else if (!en) begin
      st  <= ST_IDLE;
      div <= '0;
      idx <= '0;
    end else if (st == ST_IDLE) begin
      st  <= ST_BLANK;
      div <= '0;
      idx <= '0;
    end else if (slot_end) begin
      st  <= ST_BLANK;
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
      if (div == DIV_W'(BLANK_CYC - 1))
        st <= ST_DRIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act  <= '0;
      pnd  <= '0;
      pend <= 1'b0;
    end else begin
      if (commit) begin
        act  <= pnd;
        pend <= 1'b0;
      end
      if (accept) begin
        pnd  <= {ld.load_dp, ld.load_data};
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      an  <= drive ? ~(4'b0001 << idx) : AN_OFF;
      seg <= (drive & ~(lz_suppress & lz_blank))
             ? seg_raw : SEG_BLANK;
      dp  <= drive ? ~act.dp[idx] : 1'b1;
    end
  end

endmodule
